asym_ram_stream_ctrl: RTL and testbench

Sequencing controller for the asymmetric simple-dual-port RAM used as a weight/feature staging buffer in the CNN datapath. It accepts a frame of wide words from a loader over a valid/ready stream and writes them through the RAM's wide port A. It then reads the frame back through the narrow port B and presents it as a narrow valid/ready element stream to the compute engine, with full backpressure support. The RAM itself is instantiated beside this block; the controller only drives its ports.

---
 rtl/asym_ram_stream_ctrl.sv | 217 +++++++++++++++++++++
 tb/tb_asym_ram_stream_ctrl.sv | 250 +++++++++++++++++++++++++
 2 files changed

// File: rtl/asym_ram_stream_ctrl.sv
// asym_ram_stream_ctrl
// Sequencing controller for an asymmetric simple-dual-port staging RAM.
// A frame of FRAME_WORDS wide words is written through port A from a
// valid/ready loader stream, then read back through the narrow port B and
// presented as a narrow valid/ready element stream, lowest slice first.
// Optional feature macro: ASYM_CTRL_REPLAY_EN adds replay_num[7:0] and
// drains the stored frame replay_num+1 times back-to-back.
module asym_ram_stream_ctrl #(
  parameter int WIDTHA      = 16,
  parameter int WIDTHB      = 4,
  parameter int ADDRWIDTHA  = 8,
  parameter int ADDRWIDTHB  = 10,
  parameter int FRAME_WORDS = 256
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  start,
`ifdef ASYM_CTRL_REPLAY_EN
  input  logic [7:0]            replay_num,
`endif
  output logic                  busy,
  output logic                  done,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [WIDTHA-1:0]     in_data,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [WIDTHB-1:0]     out_data,
  output logic                  out_last,
  output logic                  ram_enaA,
  output logic                  ram_weA,
  output logic [ADDRWIDTHA-1:0] ram_addrA,
  output logic [WIDTHA-1:0]     ram_diA,
  output logic                  ram_enaB,
  output logic [ADDRWIDTHB-1:0] ram_addrB,
  input  logic [WIDTHB-1:0]     ram_doB
);

  localparam int RATIO = WIDTHA / WIDTHB;
  localparam int TOTAL = FRAME_WORDS * RATIO;
  localparam int WCW   = $clog2(FRAME_WORDS + 1);
  localparam int RCW   = $clog2(TOTAL + 1);

  localparam logic [WCW-1:0] LP_LAST_W = WCW'(FRAME_WORDS - 1);
  localparam logic [RCW-1:0] LP_LAST_R = RCW'(TOTAL - 1);
  localparam logic [RCW-1:0] LP_TOTAL  = RCW'(TOTAL);

  typedef enum logic [1:0] {
    S_IDLE,
    S_FILL,
    S_DRAIN
  } state_t;

  state_t r_state;
  state_t w_next;

  // Write/read counters sized so FRAME_WORDS and TOTAL are representable.
  logic [WCW-1:0]    r_wcnt;
  logic [RCW-1:0]    r_rcnt;

  // Read issued last cycle; its data is on ram_doB this cycle.
  logic              r_inflight;
  logic              r_inflight_last;

  // Two-entry output FIFO.
  logic [WIDTHB-1:0] r_fifo_data [2];
  logic              r_fifo_last [2];
  logic              r_wr_ptr;
  logic              r_rd_ptr;
  logic [1:0]        r_occ;

  logic              r_done;

  logic              w_wr;
  logic              w_pop;
  logic              w_issue;
  logic              w_issue_last;
  logic              w_final_pass;
  logic [1:0]        w_room;

`ifdef ASYM_CTRL_REPLAY_EN
  logic [7:0]        r_replay;
  logic [7:0]        r_pass;
  assign w_final_pass = (r_pass == r_replay);
`else
  assign w_final_pass = 1'b1;
`endif

  // State register.
  always_ff @(posedge clk) begin
    // NOTE: every clocked block uses non-blocking assignments so all
    // registers update from the same pre-edge values.
    if (rst) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_next;
    end
  end

  // Next-state decode.
  always_comb begin
    // NOTE: a default first in every combinational block keeps paths that
    // do not assign the signal from inferring a latch.
    w_next = r_state;
    case (r_state)
      S_IDLE:  if (start)                       w_next = S_FILL;
      S_FILL:  if (w_wr && r_wcnt == LP_LAST_W)  w_next = S_DRAIN;
      S_DRAIN: if (w_pop && out_last)            w_next = S_IDLE;
      default:                                   w_next = S_IDLE;
    endcase
  end

  // Output decode: handshakes, RAM port controls and the FIFO head.
  always_comb begin
    busy      = (r_state != S_IDLE);
    in_ready  = (r_state == S_FILL);
    w_wr      = in_ready && in_valid;
    ram_enaA  = w_wr;
    ram_weA   = w_wr;
    ram_addrA = w_wr ? ADDRWIDTHA'(r_wcnt) : '0;
    ram_diA   = w_wr ? in_data : '0;

    out_valid = (r_occ != 2'd0);
    out_data  = out_valid ? r_fifo_data[r_rd_ptr] : '0;
    out_last  = out_valid && r_fifo_last[r_rd_ptr];
    w_pop     = out_valid && out_ready;

    // Occupancy plus the read in flight never exceeds the FIFO depth; a
    // full pipeline may only refill in a cycle that also pops.
    w_room       = r_occ + {1'b0, r_inflight};
    w_issue      = (r_state == S_DRAIN) && (r_rcnt != LP_TOTAL) &&
                   ((w_room < 2'd2) || ((w_room == 2'd2) && w_pop));
    w_issue_last = w_issue && (r_rcnt == LP_LAST_R) && w_final_pass;
    ram_enaB     = w_issue;
    ram_addrB    = w_issue ? ADDRWIDTHB'(r_rcnt) : '0;

    done = r_done;
  end

  // Frame counters: cleared on an accepted start, advanced by writes/reads.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_wcnt <= '0;
      r_rcnt <= '0;
`ifdef ASYM_CTRL_REPLAY_EN
      r_pass   <= '0;
      r_replay <= '0;
`endif
    end else begin
      if (r_state == S_IDLE && start) begin
        r_wcnt <= '0;
        r_rcnt <= '0;
`ifdef ASYM_CTRL_REPLAY_EN
        r_pass   <= '0;
        r_replay <= replay_num;
`endif
      end
      if (w_wr) begin
        r_wcnt <= r_wcnt + WCW'(1);
      end
      if (w_issue) begin
`ifdef ASYM_CTRL_REPLAY_EN
        // Wrap straight into the next pass so passes run without a bubble.
        if (r_rcnt == LP_LAST_R && !w_final_pass) begin
          r_rcnt <= '0;
          r_pass <= r_pass + 8'd1;
        end else begin
          r_rcnt <= r_rcnt + RCW'(1);
        end
`else
        r_rcnt <= r_rcnt + RCW'(1);
`endif
      end
    end
  end

  // Read pipeline and output FIFO: capture RAM data one cycle after issue.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_inflight      <= 1'b0;
      r_inflight_last <= 1'b0;
      r_wr_ptr        <= 1'b0;
      r_rd_ptr        <= 1'b0;
      r_occ           <= 2'd0;
    end else begin
      r_inflight      <= w_issue;
      r_inflight_last <= w_issue_last;
      if (w_pop) begin
        r_rd_ptr <= ~r_rd_ptr;
      end
      if (r_inflight) begin
        r_wr_ptr <= ~r_wr_ptr;
      end
      r_occ <= r_occ + {1'b0, r_inflight} - {1'b0, w_pop};
    end
  end

  // FIFO storage.
  always_ff @(posedge clk) begin
    // NOTE: storage is not reset; emptying the FIFO (occupancy 0) is
    // sufficient because out_data and out_last are masked by out_valid.
    if (r_inflight) begin
      r_fifo_data[r_wr_ptr] <= ram_doB;
      r_fifo_last[r_wr_ptr] <= r_inflight_last;
    end
  end

  // One-cycle done pulse after the final element handshake.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_done <= 1'b0;
    end else begin
      r_done <= w_pop && out_last;
    end
  end

endmodule

// File: tb/tb_asym_ram_stream_ctrl.sv
// Testbench for asym_ram_stream_ctrl (FRAME_WORDS=4, 16-bit -> 4-bit).
// Holds a behavioural model of the asymmetric RAM beside the DUT and a
// queue of expected elements built directly from the written wide words.
module tb_asym_ram_stream_ctrl;

  localparam int WA    = 16;
  localparam int WB    = 4;
  localparam int AWA   = 8;
  localparam int AWB   = 10;
  localparam int FW    = 4;
  localparam int RATIO = WA / WB;
  localparam int TOTAL = FW * RATIO;

  logic           clk = 1'b0;
  logic           rst;
  logic           start;
  logic           busy;
  logic           done;
  logic           in_valid;
  logic           in_ready;
  logic [WA-1:0]  in_data;
  logic           out_valid;
  logic           out_ready;
  logic [WB-1:0]  out_data;
  logic           out_last;
  logic           ram_enaA;
  logic           ram_weA;
  logic [AWA-1:0] ram_addrA;
  logic [WA-1:0]  ram_diA;
  logic           ram_enaB;
  logic [AWB-1:0] ram_addrB;
  logic [WB-1:0]  ram_doB = '0;
`ifdef ASYM_CTRL_REPLAY_EN
  logic [7:0]     replay_num = 8'd0;
`endif

  int n_tests = 0;
  int n_fail  = 0;

  logic [WA-1:0] frame_words [FW];
  logic [WA-1:0] mem [0:(1<<AWA)-1];

  asym_ram_stream_ctrl #(
    .WIDTHA(WA), .WIDTHB(WB), .ADDRWIDTHA(AWA), .ADDRWIDTHB(AWB),
    .FRAME_WORDS(FW)
  ) dut (
    .clk(clk), .rst(rst), .start(start),
`ifdef ASYM_CTRL_REPLAY_EN
    .replay_num(replay_num),
`endif
    .busy(busy), .done(done),
    .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
    .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
    .out_last(out_last),
    .ram_enaA(ram_enaA), .ram_weA(ram_weA), .ram_addrA(ram_addrA),
    .ram_diA(ram_diA), .ram_enaB(ram_enaB), .ram_addrB(ram_addrB),
    .ram_doB(ram_doB)
  );

  always #5 clk = ~clk;

  // Asymmetric RAM: wide write port, narrow registered read port.
  always @(posedge clk) begin
    if (ram_enaA && ram_weA) mem[ram_addrA] <= ram_diA;
    if (ram_enaB) ram_doB <= mem[ram_addrB[AWB-1:2]][{ram_addrB[1:0], 2'b00} +: WB];
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // Advance to 1ns after the next rising edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // gap_mode: 0 none, 1 fixed gaps with start pulses, 2 random gaps.
  // ready_mode: 0 always ready, 1 scripted stalls with a start pulse, 2 random.
  // abort_at: reset after this many elements (0 = run to completion).
  task automatic run_frame(input int gap_mode, input int ready_mode,
                           input int passes, input int abort_at);
    logic [WB-1:0] exp_q[$];
    int gap_tab[FW] = '{0, 1, 3, 1};
    int gap, c, idx, last_c, expa, p;
    bit first, finished, prev_stall, aborted;
    logic [WB-1:0] prev_data;
    logic prev_last;

    for (int ps = 0; ps < passes; ps++)
      for (int j = 0; j < FW; j++)
        for (int k = 0; k < RATIO; k++)
          exp_q.push_back(WB'((frame_words[j] >> (WB * k)) & 16'hF));

`ifdef ASYM_CTRL_REPLAY_EN
    replay_num = 8'(passes - 1);
`endif
    start = 1'b1;
    tick();
    start = 1'b0;
`ifdef ASYM_CTRL_REPLAY_EN
    replay_num = 8'($urandom);
`endif

    // FILL
    first = 1'b1;
    for (int j = 0; j < FW; j++) begin
      gap = (gap_mode == 1) ? gap_tab[j] : (gap_mode == 2) ? int'($urandom_range(3)) : 0;
      for (int g = 0; g < gap; g++) begin
        in_valid = 1'b0;
        in_data  = WA'($urandom);
        start    = (gap_mode == 1);
        #1;
        if (first) begin
          check("fill_busy", busy, 1); check("fill_in_ready", in_ready, 1);
          check("fill_done_low", done, 0);
        end
        first = 1'b0;
        check("gap_no_write", ram_enaA, 0);
        check("gap_in_ready", in_ready, 1);
        tick();
        start = 1'b0;
      end
      in_valid = 1'b1;
      in_data  = frame_words[j];
      #1;
      if (first) begin
        check("fill_busy", busy, 1); check("fill_in_ready", in_ready, 1);
        check("fill_done_low", done, 0);
      end
      first = 1'b0;
      check("wr_en", ram_enaA & ram_weA, 1);
      check("wr_addr", ram_addrA, j);
      check("wr_data", ram_diA, frame_words[j]);
      tick();
    end
    in_valid = 1'b0;
    in_data  = WA'($urandom);

    // DRAIN
    c = 0; idx = 0; expa = 0; last_c = 0;
    finished = 1'b0; aborted = 1'b0; prev_stall = 1'b0;
    prev_data = '0; prev_last = 1'b0;
    while (!finished && c < 2000) begin
      c++;
      if (ready_mode == 0) out_ready = 1'b1;
      else if (ready_mode == 1) begin
        p = c - 3;
        out_ready = (p < 0) ? 1'b1 : (p < 4) ? ((p % 2) == 0) : (p < 9) ? 1'b0 : 1'b1;
      end else out_ready = ($urandom_range(99) < 60);
      start = (ready_mode == 1 && c == 5);
      #1;
      if (c == 1) begin
        check("first_read_en", ram_enaB, 1);
        check("first_read_addr", ram_addrB, 0);
      end
      if (c < 3) check("no_early_valid", out_valid, 0);
      if (c == 3) check("first_valid", out_valid, 1);
      check("drain_in_ready", in_ready, 0);
      check("drain_busy", busy, 1);
      check("drain_done_low", done, 0);
      if (ram_enaB) begin
        check("read_addr", ram_addrB, expa);
        expa = (expa + 1) % TOTAL;
      end
      if (prev_stall) begin
        check("stall_data", out_data, prev_data);
        check("stall_last", out_last, prev_last);
      end
      prev_stall = out_valid && !out_ready;
      prev_data  = out_data;
      prev_last  = out_last;
      if (out_valid && out_ready) begin
        check("elem_data", out_data, exp_q[idx]);
        check("elem_last", out_last, (idx == exp_q.size() - 1));
        idx++;
        if (idx == exp_q.size()) begin finished = 1'b1; last_c = c; end
        if (idx == abort_at) begin finished = 1'b1; aborted = 1'b1; end
      end
      tick();
      start = 1'b0;
    end
    if (!finished) check("drain_timeout", idx, exp_q.size());

    if (aborted) begin
      out_ready = 1'b0;
      rst = 1'b1;
      tick();
      rst = 1'b0;
      #1;
      check("abort_busy", busy, 0);       check("abort_done", done, 0);
      check("abort_in_ready", in_ready, 0); check("abort_out_valid", out_valid, 0);
      check("abort_out_data", out_data, 0); check("abort_out_last", out_last, 0);
      check("abort_enaA", ram_enaA, 0);   check("abort_weA", ram_weA, 0);
      check("abort_addrA", ram_addrA, 0); check("abort_diA", ram_diA, 0);
      check("abort_enaB", ram_enaB, 0);   check("abort_addrB", ram_addrB, 0);
      for (int i = 0; i < 3; i++) begin
        tick();
        #1;
        check("abort_no_done", done, 0);
        check("abort_idle", busy, 0);
      end
    end else begin
      out_ready = 1'b0;
      #1;
      check("done_pulse", done, 1);
      check("done_busy_low", busy, 0);
      check("done_out_valid", out_valid, 0);
      if (ready_mode == 0) check("throughput", last_c, exp_q.size() + 2);
    end
  endtask

  initial begin
    rst = 1'b1; start = 1'b0; in_valid = 1'b0; in_data = '0; out_ready = 1'b0;
    repeat (2) tick();
    rst = 1'b0;
    #1;
    check("rst_busy", busy, 0);         check("rst_done", done, 0);
    check("rst_in_ready", in_ready, 0); check("rst_out_valid", out_valid, 0);
    check("rst_enaA", ram_enaA, 0);     check("rst_enaB", ram_enaB, 0);

    frame_words = '{16'h3210, 16'h7654, 16'hBA98, 16'hFEDC};
    run_frame(0, 0, 1, 0);   // streaming, no backpressure
    run_frame(0, 1, 1, 0);   // scripted stalls, start during DRAIN; begins the cycle after done
    run_frame(1, 0, 1, 0);   // input gaps, start during FILL
    run_frame(0, 2, 1, 6);   // reset after the 6th element
    run_frame(0, 0, 1, 0);   // fresh frame after the abort

    for (int n = 0; n < 6; n++) begin
      for (int j = 0; j < FW; j++) frame_words[j] = WA'($urandom);
      run_frame(2, 2, 1, 0);
    end

`ifdef ASYM_CTRL_REPLAY_EN
    frame_words = '{16'h3210, 16'h7654, 16'hBA98, 16'hFEDC};
    run_frame(0, 0, 3, 0);
    for (int j = 0; j < FW; j++) frame_words[j] = WA'($urandom);
    run_frame(2, 2, 2, 0);
`endif

    tick();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
